// File: rtl/load_store_unit.sv
// Load/store unit: one byte/half/word request at a time between the memory
// stage and a word-addressed data memory. Sub-word stores are done as a
// read-modify-write; loads are lane-extracted and zero/sign-extended.
module load_store_unit #(
    parameter int MEM_WORDS = 65
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        MERGE,
        RESP
    } state_t;

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        we_q;

    logic        req_error;
    logic [4:0]  byte_shamt;
    logic [4:0]  half_shamt;
    logic [31:0] byte_shifted;
    logic [31:0] half_shifted;
    logic [31:0] load_value;
    logic [31:0] merged_word;

    // Reject illegal size, misalignment and out-of-range word index at accept time
    always_comb begin
        req_error = 1'b0;
        if (req_size == 2'b11)
            req_error = 1'b1;
        else if (req_size == 2'b01 && req_addr[0])
            req_error = 1'b1;
        else if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            req_error = 1'b1;
        else if (req_addr[31:2] >= WORD_LIMIT)
            req_error = 1'b1;
    end

    // Little-endian lane extraction for loads and lane replacement for sub-word stores
    always_comb begin
        byte_shamt   = {addr_q[1:0], 3'b000};
        half_shamt   = {addr_q[1], 4'b0000};
        byte_shifted = mem_rd >> byte_shamt;
        half_shifted = mem_rd >> half_shamt;
        load_value   = mem_rd;
        merged_word  = mem_rd;
        case (size_q)
            2'b00: begin
                load_value  = {{24{signed_q & byte_shifted[7]}}, byte_shifted[7:0]};
                merged_word = (mem_rd & ~(32'h0000_00FF << byte_shamt))
                            | ({24'b0, wdata_q[7:0]} << byte_shamt);
            end
            2'b01: begin
                load_value  = {{16{signed_q & half_shifted[15]}}, half_shifted[15:0]};
                merged_word = (mem_rd & ~(32'h0000_FFFF << half_shamt))
                            | ({16'b0, wdata_q[15:0]} << half_shamt);
            end
            default: begin
                load_value  = mem_rd;
                merged_word = mem_rd;
            end
        endcase
    end

    // Request sequencer: all handshake and memory-port outputs are registered here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            mem_we     <= 1'b0;
            mem_a      <= 32'h0;
            mem_wd     <= 32'h0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        size_q    <= req_size;
                        signed_q  <= req_signed;
                        we_q      <= req_we;
                        req_ready <= 1'b0;
                        if (req_error) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                            state      <= RESP;
                        end else begin
                            mem_a  <= {req_addr[31:2], 2'b00};
                            mem_we <= req_we && (req_size == 2'b10);
                            if (req_we && req_size == 2'b10)
                                mem_wd <= req_wdata;
                            state  <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_value;
                        state      <= RESP;
                    end else if (size_q == 2'b10) begin
                        mem_we     <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= 32'h0;
                        state      <= RESP;
                    end else begin
                        mem_we <= 1'b1;
                        mem_wd <= merged_word;
                        state  <= MERGE;
                    end
                end
                MERGE: begin
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'h0;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: a behavioural data memory plus a word-array
// reference model; directed scenarios followed by randomized requests.
module tb_load_store_unit;

    localparam int MEM_WORDS = 65;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_mem [MEM_WORDS];
    logic [31:0] mem     [MEM_WORDS];
    logic        init_mem;
    logic        in_range;
    logic [6:0]  mem_idx;
    logic [31:0] last_rdata;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] initWord(int i);
        return (32'h9E3779B9 * 32'(i + 1)) ^ 32'h5A5A0F0F;
    endfunction

    // Data memory: combinational read, write committed on the falling edge
    assign in_range = mem_a[31:2] < 30'(MEM_WORDS);
    assign mem_idx  = mem_a[8:2];
    assign mem_rd   = in_range ? mem[mem_idx] : 32'h0;

    always @(negedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= initWord(i);
        end else if (mem_we && in_range) begin
            mem[mem_idx] <= mem_wd;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference rules, written directly from the request semantics
    function automatic logic modelError(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'b11) return 1'b1;
        if (size == 2'b01 && addr[0]) return 1'b1;
        if (size == 2'b10 && addr[1:0] != 2'b00) return 1'b1;
        return (addr >> 2) >= 32'(MEM_WORDS);
    endfunction

    function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
        logic [31:0] word;
        logic [31:0] v;
        word = ref_mem[addr[8:2]];
        case (size)
            2'b00: begin
                v = (word >> (int'(addr[1:0]) * 8)) & 32'h0000_00FF;
                if (sgn && v[7]) v = v | 32'hFFFF_FF00;
            end
            2'b01: begin
                v = (word >> (int'(addr[1]) * 16)) & 32'h0000_FFFF;
                if (sgn && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    task automatic modelStore(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        int idx;
        idx = int'(addr[8:2]);
        case (size)
            2'b00:   ref_mem[idx][int'(addr[1:0]) * 8 +: 8]  = wdata[7:0];
            2'b01:   ref_mem[idx][int'(addr[1]) * 16 +: 16] = wdata[15:0];
            default: ref_mem[idx] = wdata;
        endcase
    endtask

    // One complete request: wait for ready, accept, follow it to its response
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_lat;
        int          cycles;
        int          we_count;
        int          ready_bad;
        int          wait_cnt;
        int          idx;
        exp_err  = modelError(size, addr);
        exp_data = (!exp_err && !we) ? modelLoad(size, sgn, addr) : 32'h0;
        exp_lat  = exp_err ? 1 : ((we && size != 2'b10) ? 3 : 2);
        idx      = int'(addr[8:2]);

        wait_cnt = 0;
        @(negedge clk);
        while (!req_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!req_ready) begin
            checkOutput("ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;

        cycles    = 0;
        we_count  = 0;
        ready_bad = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (mem_we) we_count++;
            if (req_ready) ready_bad++;
        end while (!resp_valid && cycles < 10);

        last_rdata = resp_rdata;
        checkOutput("resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("latency", 32'(cycles), 32'(exp_lat));
        checkOutput("resp_err", 32'(resp_err), 32'(exp_err));
        checkOutput("resp_rdata", resp_rdata, exp_data);
        checkOutput("mem_we_cycles", 32'(we_count), (!exp_err && we) ? 32'd1 : 32'd0);
        checkOutput("ready_busy", 32'(ready_bad), 32'd0);
        if (!exp_err && we) modelStore(size, addr, wdata);
        if (!exp_err) checkOutput("mem_word", mem[idx], ref_mem[idx]);

        @(negedge clk);
        checkOutput("resp_pulse", 32'(resp_valid), 32'd0);
        checkOutput("ready_back", 32'(req_ready), 32'd1);
    endtask

    // Three loads queued with req_valid held high the whole time
    task automatic backToBack();
        logic [1:0]  sizes [3];
        logic        sgns  [3];
        logic [31:0] addrs [3];
        logic [31:0] exps  [3];
        int          acc;
        int          rsp;
        int          last_acc;
        logic        will_acc;
        sizes[0] = 2'b10; sgns[0] = 1'b0; addrs[0] = 32'h20;
        sizes[1] = 2'b00; sgns[1] = 1'b1; addrs[1] = 32'h25;
        sizes[2] = 2'b01; sgns[2] = 1'b0; addrs[2] = 32'h2A;
        for (int i = 0; i < 3; i++) exps[i] = modelLoad(sizes[i], sgns[i], addrs[i]);

        acc      = 0;
        rsp      = 0;
        last_acc = 0;
        @(negedge clk);
        req_we     = 1'b0;
        req_size   = sizes[0];
        req_signed = sgns[0];
        req_addr   = addrs[0];
        req_wdata  = 32'h0;
        req_valid  = 1'b1;
        for (int c = 0; c < 20 && rsp < 3; c++) begin
            if (resp_valid && rsp < 3) begin
                checkOutput("b2b_rdata", resp_rdata, exps[rsp]);
                checkOutput("b2b_err", 32'(resp_err), 32'd0);
                rsp++;
            end
            will_acc = req_valid && req_ready;
            @(posedge clk);
            if (will_acc) begin
                if (acc > 0) checkOutput("b2b_gap", 32'(c - last_acc), 32'd3);
                last_acc = c;
                acc++;
                #1;
                if (acc < 3) begin
                    req_size   = sizes[acc];
                    req_signed = sgns[acc];
                    req_addr   = addrs[acc];
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checkOutput("b2b_accepts", 32'(acc), 32'd3);
        checkOutput("b2b_responses", 32'(rsp), 32'd3);
    endtask

    // Reset lands in MERGE before its falling edge: the write must be lost
    task automatic resetDuringMerge();
        int resp_seen;
        @(negedge clk);
        req_we     = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h31;
        req_wdata  = 32'h0000_005A;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 checkOutput("merge_we", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        #1 checkOutput("rst_mem_unchanged", mem[12], ref_mem[12]);
        @(posedge clk);
        #1 rst = 1'b0;
        resp_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
        end
        checkOutput("rst_no_resp", 32'(resp_seen), 32'd0);
        checkOutput("rst_ready_after", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic        r_we;
        logic [1:0]  r_size;
        logic        r_sgn;
        logic [31:0] r_addr;
        int          r_sel;
        int          r_off;

        rst        = 1'b1;
        init_mem   = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        last_rdata = 32'h0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = initWord(i);
        repeat (2) @(negedge clk);
        init_mem = 1'b0;

        checkOutput("reset_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset_rdata", resp_rdata, 32'h0);
        checkOutput("reset_err", 32'(resp_err), 32'd0);
        checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset_mem_a", mem_a, 32'h0);
        checkOutput("reset_mem_wd", mem_wd, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] directed: word store and load");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        checkOutput("plan_word_mem", mem[4], 32'hDEADBEEF);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checkOutput("plan_word_load", last_rdata, 32'hDEADBEEF);

        $display("[TB] directed: byte store and loads");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB);
        checkOutput("plan_byte_mem", mem[4], 32'h1122AB44);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        checkOutput("plan_sbyte", last_rdata, 32'hFFFF_FFAB);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        checkOutput("plan_ubyte", last_rdata, 32'h0000_00AB);

        $display("[TB] directed: half store and loads");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001);
        checkOutput("plan_half_mem", mem[4], 32'h80013344);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        checkOutput("plan_shalf", last_rdata, 32'hFFFF_8001);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        checkOutput("plan_uhalf", last_rdata, 32'h0000_8001);

        $display("[TB] directed: error cases");
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_1234);
        checkOutput("err_no_write", mem[4], 32'h80013344);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);

        $display("[TB] back-to-back loads");
        backToBack();

        $display("[TB] reset during merge");
        resetDuringMerge();

        $display("[TB] randomized requests");
        for (int n = 0; n < 80; n++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_sgn  = 1'($urandom_range(0, 1));
            r_sel  = int'($urandom_range(0, 15));
            r_size = (r_sel == 0) ? 2'b11 : 2'(r_sel % 3);
            if ($urandom_range(0, 3) != 0) begin
                if (r_size == 2'b10)      r_off = 0;
                else if (r_size == 2'b01) r_off = 2 * int'($urandom_range(0, 1));
                else                      r_off = int'($urandom_range(0, 3));
            end else begin
                r_off = int'($urandom_range(0, 3));
            end
            r_addr = 32'(int'($urandom_range(0, MEM_WORDS + 2)) * 4 + r_off);
            if ($urandom_range(0, 19) == 0) r_addr = $urandom | 32'h8000_0000;
            applyStimulus(r_we, r_size, r_sgn, r_addr, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
